// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion controller.
//   state_e    : frame update sequencer states
//   KEY_*      : USB HID keycodes that steer the ball
//   FRAC_BITS  : fractional bits of the 10.4 fixed-point position
//   RESET_X/Y  : integer start position (screen centre)
//   axis_step  : one-axis position advance with wall bounce
package ball_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRotate,
    StLookupX,
    StLookupY,
    StMove
  } state_e;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  localparam int unsigned FRAC_BITS = 4;
  localparam int unsigned RESET_X   = 320;
  localparam int unsigned RESET_Y   = 240;

  typedef struct packed {
    logic        [13:0] pos;
    logic signed [13:0] vel;
  } axis_t;

  // Advance one axis by vel; clamp to [lo, hi] (integer pixels) and reflect
  // the velocity whenever the new position falls outside that range.
  function automatic axis_t axis_step(input logic [13:0] pos, input logic signed [13:0] vel,
                                      input int unsigned lo, input int unsigned hi);
    logic signed [14:0] sum;
    logic signed [10:0] ipos;
    axis_t              r;
    sum   = $signed({1'b0, pos}) + $signed({vel[13], vel});
    // Arithmetic floor of the fixed-point sum; negative sums stay negative.
    ipos  = sum[14:FRAC_BITS];
    r.pos = sum[13:0];
    r.vel = vel;
    if (ipos > $signed(11'(hi))) begin
      r.pos = 14'(hi << FRAC_BITS);
      r.vel = -vel;
    end else if (ipos < $signed(11'(lo))) begin
      r.pos = 14'(lo << FRAC_BITS);
      r.vel = -vel;
    end
    return r;
  endfunction

endpackage

// File: rtl/cos_rom.sv
// 64-entry signed cosine table, value = round(127 * cos(2*pi*addr/64)).
//   addr_i : angle, 64 steps per revolution
//   data_o : signed 8-bit cosine
// Only the first quadrant is stored; the rest follows by symmetry.
module cos_rom (
  input  logic        [5:0] addr_i,
  output logic signed [7:0] data_o
);

  logic [1:0] quad;
  logic [3:0] rem;
  logic [4:0] idx;
  logic [6:0] mag;
  logic       neg;

  assign quad = addr_i[5:4];
  assign rem  = addr_i[3:0];
  // Quadrants 1 and 3 run the quarter table backwards.
  assign idx  = quad[0] ? (5'd16 - {1'b0, rem}) : {1'b0, rem};
  // Cosine is negative in quadrants 1 and 2.
  assign neg  = quad[0] ^ quad[1];

  always_comb begin
    mag = 7'd0;
    unique case (idx)
      5'd0:    mag = 7'd127;
      5'd1:    mag = 7'd126;
      5'd2:    mag = 7'd125;
      5'd3:    mag = 7'd122;
      5'd4:    mag = 7'd117;
      5'd5:    mag = 7'd112;
      5'd6:    mag = 7'd106;
      5'd7:    mag = 7'd98;
      5'd8:    mag = 7'd90;
      5'd9:    mag = 7'd81;
      5'd10:   mag = 7'd71;
      5'd11:   mag = 7'd60;
      5'd12:   mag = 7'd49;
      5'd13:   mag = 7'd37;
      5'd14:   mag = 7'd25;
      5'd15:   mag = 7'd12;
      default: mag = 7'd0;
    endcase
  end

  assign data_o = neg ? $signed(-{1'b0, mag}) : $signed({1'b0, mag});

endmodule

// File: rtl/ball_motion.sv
// Frame-rate motion controller for the player ball.
//   Clk        : system clock
//   Reset_n    : asynchronous active-low reset
//   frame_clk  : vsync level; each rising edge starts one update
//   keycode    : USB HID keycode (A/D rotate, W thrust, S stop)
//   BallX/Y    : integer ball position
//   Ball_size  : constant radius BALL_SIZE
//   BallAngle  : heading, 64 steps per turn, increasing toward screen-down
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned BALL_SIZE = 4,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [5:0] BallAngle
);

  state_e             state_q, state_d;
  logic               frame_clk_q;
  logic               frame_edge;
  logic        [5:0]  angle_q, angle_d;
  logic signed [7:0]  cos_q, cos_d;
  logic signed [7:0]  sin_q, sin_d;
  logic signed [13:0] vel_x_q, vel_x_d;
  logic signed [13:0] vel_y_q, vel_y_d;
  logic        [13:0] pos_x_q, pos_x_d;
  logic        [13:0] pos_y_q, pos_y_d;

  logic        [5:0]  rom_addr;
  logic signed [7:0]  rom_data;
  logic signed [13:0] vx, vy;
  axis_t              ax, ay;

  assign frame_edge = frame_clk & ~frame_clk_q;

  // One ROM shared by both lookups; sin(a) = cos(a - 16).
  assign rom_addr = (state_q == StLookupY) ? (angle_q - 6'd16) : angle_q;

  cos_rom u_cos_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vx      = vel_x_q;
    vy      = vel_y_q;
    ax      = '0;
    ay      = '0;
    unique case (state_q)
      StIdle: begin
        if (frame_edge) state_d = StRotate;
      end
      StRotate: begin
        if (keycode == KEY_A)      angle_d = angle_q - 6'd1;
        else if (keycode == KEY_D) angle_d = angle_q + 6'd1;
        state_d = StLookupX;
      end
      StLookupX: begin
        cos_d   = rom_data;
        state_d = StLookupY;
      end
      StLookupY: begin
        sin_d   = rom_data;
        state_d = StMove;
      end
      StMove: begin
        if (keycode == KEY_W) begin
          vx = {{6{cos_q[7]}}, cos_q};
          vy = {{6{sin_q[7]}}, sin_q};
        end else if (keycode == KEY_S) begin
          vx = '0;
          vy = '0;
        end
        ax      = axis_step(pos_x_q, vx, BALL_SIZE, X_MAX - BALL_SIZE);
        ay      = axis_step(pos_y_q, vy, BALL_SIZE, Y_MAX - BALL_SIZE);
        pos_x_d = ax.pos;
        vel_x_d = ax.vel;
        pos_y_d = ay.pos;
        vel_y_d = ay.vel;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      frame_clk_q <= 1'b0;
      angle_q     <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      vel_x_q     <= '0;
      vel_y_q     <= '0;
      pos_x_q     <= 14'(RESET_X << FRAC_BITS);
      pos_y_q     <= 14'(RESET_Y << FRAC_BITS);
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk;
      angle_q     <= angle_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  assign BallX     = pos_x_q[13:FRAC_BITS];
  assign BallY     = pos_y_q[13:FRAC_BITS];
  assign Ball_size = 10'(BALL_SIZE);
  assign BallAngle = angle_q;

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_D = 8'h07;
  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_S = 8'h16;
  localparam real        PI  = 3.14159265358979;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, Ball_size;
  logic [5:0] BallAngle;

  int total = 0;
  int bad   = 0;

  // Reference state: angle 0..63, positions in 1/16 pixel, velocities in 1/16 pixel/frame.
  int m_ang, m_px, m_py, m_vx, m_vy;

  ball_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .BallX     (BallX),
    .BallY     (BallY),
    .Ball_size (Ball_size),
    .BallAngle (BallAngle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cos_ref(input int a);
    real r;
    r = 127.0 * $cos(2.0 * PI * real'(a) / 64.0);
    return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
  endfunction

  task automatic axis_ref(input int p, input int v, input int mx, output int np, output int nv);
    int n, ip;
    n  = p + v;
    ip = (n < 0) ? -1 : n / 16;
    np = n;
    nv = v;
    if (ip + 4 > mx) begin
      np = (mx - 4) * 16;
      nv = -v;
    end else if (ip < 4) begin
      np = 4 * 16;
      nv = -v;
    end
  endtask

  task automatic model_reset();
    m_ang = 0;
    m_px  = 320 * 16;
    m_py  = 240 * 16;
    m_vx  = 0;
    m_vy  = 0;
  endtask

  task automatic model_rotate(input logic [7:0] key);
    if (key == K_A) m_ang = (m_ang + 63) % 64;
    else if (key == K_D) m_ang = (m_ang + 1) % 64;
  endtask

  task automatic model_move(input logic [7:0] key);
    int p, v;
    if (key == K_W) begin
      m_vx = cos_ref(m_ang);
      m_vy = cos_ref((m_ang + 48) % 64);
    end else if (key == K_S) begin
      m_vx = 0;
      m_vy = 0;
    end
    axis_ref(m_px, m_vx, 639, p, v);
    m_px = p;
    m_vx = v;
    axis_ref(m_py, m_vy, 479, p, v);
    m_py = p;
    m_vy = v;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    #1;
    model_reset();
    chk("rst_x", int'(BallX), 320);
    chk("rst_y", int'(BallY), 240);
    chk("rst_angle", int'(BallAngle), 0);
    chk("rst_size", int'(Ball_size), 4);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // One full frame; frame_clk stays high for several cycles to exercise edge detection.
  task automatic do_frame(input logic [7:0] key);
    int old_x, old_y;
    old_x   = m_px / 16;
    old_y   = m_py / 16;
    keycode = key;
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    model_rotate(key);
    chk("mid_angle", int'(BallAngle), m_ang);
    chk("mid_x_stable", int'(BallX), old_x);
    chk("mid_y_stable", int'(BallY), old_y);
    repeat (3) @(negedge Clk);
    model_move(key);
    chk("frame_x", int'(BallX), m_px / 16);
    chk("frame_y", int'(BallY), m_py / 16);
    chk("frame_angle", int'(BallAngle), m_ang);
    repeat (2) @(negedge Clk);
    chk("held_x", int'(BallX), m_px / 16);
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0] keys [7];
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    keys[0] = 8'h00; keys[1] = K_A; keys[2] = K_D; keys[3] = K_W;
    keys[4] = K_W;   keys[5] = K_S; keys[6] = 8'h55;
    model_reset();

    // Idle frames leave everything at the centre.
    do_reset();
    repeat (3) begin
      do_frame(8'h00);
      chk("idle_x", int'(BallX), 320);
      chk("idle_y", int'(BallY), 240);
      chk("idle_angle", int'(BallAngle), 0);
    end

    // Thrust along +X.
    do_frame(K_W);
    chk("w1_x", int'(BallX), 327);
    chk("w1_posx", int'(dut.pos_x_q), 5247);
    do_frame(K_W);
    chk("w2_x", int'(BallX), 335);
    chk("w2_posx", int'(dut.pos_x_q), 5374);
    chk("w2_y", int'(BallY), 240);

    // Rotation wraps both ways.
    do_frame(K_A);
    chk("a_wrap", int'(BallAngle), 63);
    do_frame(K_D);
    do_frame(K_D);
    chk("d_wrap", int'(BallAngle), 1);

    // Right-wall bounce.
    do_reset();
    repeat (16) do_frame(K_D);
    chk("angle16", int'(BallAngle), 16);
    repeat (16) do_frame(K_A);
    chk("angle0", int'(BallAngle), 0);
    for (int i = 0; i < 60; i++) begin
      do_frame(K_W);
      chk("wall_bound", int'(BallX <= 10'd635), 1);
      if (m_vx < 0) break;
    end
    chk("wall_x", int'(BallX), 635);
    chk("wall_vx", int'($signed(dut.vel_x_q)), -127);
    do_frame(8'h00);
    chk("wall_retreat", int'(BallX < 10'd635), 1);

    // Corner: line up so both axes cross their limits in the same frame.
    do_reset();
    repeat (11) do_frame(K_W);
    do_frame(K_S);
    repeat (16) do_frame(K_D);
    do_frame(K_W);
    do_frame(K_S);
    repeat (8) do_frame(K_A);
    chk("corner_angle", int'(BallAngle), 8);
    for (int i = 0; i < 60; i++) begin
      do_frame(K_W);
      if (m_vx < 0 || m_vy < 0) break;
    end
    chk("corner_x", int'(BallX), 635);
    chk("corner_y", int'(BallY), 475);
    chk("corner_vx", int'($signed(dut.vel_x_q)), -90);
    chk("corner_vy", int'($signed(dut.vel_y_q)), -90);

    // Second edge while busy must be ignored.
    do_reset();
    keycode = K_W;
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (12) @(negedge Clk);
    model_rotate(K_W);
    model_move(K_W);
    chk("dbl_edge_x", int'(BallX), 327);
    chk("dbl_edge_posx", int'(dut.pos_x_q), m_px);
    frame_clk = 1'b0;
    @(negedge Clk);

    // Reset mid-update discards the partial frame.
    do_reset();
    keycode = K_A;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    chk("pre_rst_angle", int'(BallAngle), 63);
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_x", int'(BallX), 320);
    chk("mid_rst_y", int'(BallY), 240);
    chk("mid_rst_angle", int'(BallAngle), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    do_frame(K_W);
    chk("post_rst_x", int'(BallX), 327);

    // Random key sequences against the reference model.
    for (int i = 0; i < 80; i++) begin
      do_frame(keys[$urandom_range(0, 6)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Frame-rate motion controller for the player ball. On each rising edge of `frame_clk` (vsync), it reads the current USB keycode and updates three things: heading angle, velocity and position. Position is kept in 10.4 fixed point, and the ball bounces off the screen edges. It sits directly upstream of the colour mapper and drives its `BallX`, `BallY`, `Ball_size` and `BallAngle` inputs.

## Interface

Parameters:
- `BALL_SIZE`, default 4: radius in pixels, driven constant on `Ball_size`.
- `X_MAX`, default 639: rightmost visible column.
- `Y_MAX`, default 479: bottom visible row.

Ports:
- `Clk`  in  1: system clock. The only clock.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `frame_clk`  in  1: vsync level, synchronous to `Clk`; only its rising edge is used.
- `keycode`  in  8: USB HID keycode. 0x04=A, 0x07=D, 0x1A=W, 0x16=S; anything else means no key.
- `BallX`  out  10: integer X position (`posX[13:4]`).
- `BallY`  out  10: integer Y position (`posY[13:4]`).
- `Ball_size`  out  10: `BALL_SIZE`, constant.
- `BallAngle`  out  6: heading. 64 steps per revolution; 0 = +X; increasing angle turns toward +Y (screen down).

## Operation

- Edge detect: register `frame_clk`; `frame_edge = frame_clk & ~frame_clk_q`.
- FSM states:
  - IDLE -> ROTATE on `frame_edge`.
  - ROTATE -> LOOKUP_X -> LOOKUP_Y -> MOVE -> IDLE, unconditionally.
- ROTATE:
  - A: `BallAngle` -= 1.
  - D: `BallAngle` += 1.
  - The angle wraps mod 64: 0-1 = 63, 63+1 = 0.
- LOOKUP_X: ROM address = `BallAngle`. Latch the signed 8-bit ROM output as `cosv`.
- LOOKUP_Y: ROM address = `BallAngle` - 16 (mod 64), which gives sin. Latch as `sinv`.
- MOVE, velocity update:
  - W: `velX = cosv`, `velY = sinv` (sign-extended to 14 bits).
  - S: `velX = velY = 0`.
  - Other keys: velocity unchanged.
- MOVE, position update:
  - The new velocity is used.
  - Position advances by `pos += vel`, computed in a signed 15-bit intermediate.
- Bounce, X axis:
  - If the new integer X + `BALL_SIZE` > `X_MAX`: set `posX = (X_MAX-BALL_SIZE)<<4` and `velX = -velX`.
  - If the new integer X < `BALL_SIZE` (including negative results): set `posX = BALL_SIZE<<4` and `velX = -velX`.
- Bounce, Y axis: same rules as X, using `Y_MAX`.
- Corner hit: both axes are handled independently in the same MOVE.
- Clamping guarantees the integer position never leaves [`BALL_SIZE`, MAX-`BALL_SIZE`].
- Angle is unaffected by bounces.

## Timing

- Reset values (asynchronous, while `Reset_n`=0):
  - `posX` = 320<<4, `posY` = 240<<4, so `BallX`=320, `BallY`=240.
  - `BallAngle`=0, `velX`=`velY`=0.
  - FSM=IDLE; `frame_clk_q`=0.
  - `Ball_size`=`BALL_SIZE` always.
- `keycode` is sampled in two places:
  - in ROTATE, for rotation;
  - in MOVE, for velocity.
- Latency and output stability:
  - `BallAngle` changes at the end of ROTATE, 2 cycles after the edge is registered.
  - `BallX`/`BallY` change at the end of MOVE, 5 cycles after the `frame_clk` rise.
  - Outputs are stable at all other times.
- A `frame_clk` rising edge arriving while the FSM is not in IDLE is ignored; no pending flag.
- Reset asserted mid-sequence returns to the reset values immediately; the partial update is discarded.
- `frame_clk` held high produces exactly one update.

## Structure

- Package `ball_pkg`:
  - FSM state enum;
  - keycode constants `KEY_A`, `KEY_D`, `KEY_W`, `KEY_S`;
  - `FRAC_BITS`=4;
  - reset position constants.
- Sub-module `cos_rom`:
  - the existing 64-entry, 6-bit address, 8-bit signed, combinational ROM;
  - value = round(127·cos(2πa/64));
  - a single instance, time-multiplexed across LOOKUP_X/LOOKUP_Y.
- Target 150–250 lines of RTL.

## Test plan

- Reset, then 3 frames with `keycode`=0: `BallX`=320, `BallY`=240, `BallAngle`=0 throughout.
- W held, angle 0, 2 frames: `BallX` 327, then 335 (posX 5247, then 5374); `BallY`=240.
- A held 1 frame from 0: `BallAngle`=63. D held 2 frames from 63: `BallAngle`=1.
- Right-wall bounce:
  - stimulus: D×16 to angle 16, then A×16 back to 0, then W until a bounce;
  - required: `BallX` never exceeds 635; at impact `BallX`=635 and `velX`=-127;
  - next frame with no key: `BallX` decreases.
- Corner hit: with angle 8 and W held, the ball reaches the bottom-right corner; both velocities negate in the same frame; `BallX`=635 and `BallY`=475.
- Robustness:
  - stimulus 1: a second `frame_clk` edge injected 2 cycles after the first;
  - required: exactly one update.
  - stimulus 2: `Reset_n` pulsed low during LOOKUP_Y;
  - required: outputs 320/240/0, next edge processed normally.
